// File: rtl/store_buffer_pkg.sv
// Shared defaults and the buffered-store record for the store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH        = 4;
    localparam int SB_STARVE_LIMIT = 4;
    localparam int SB_MATCH_BITS   = 3;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        valid;
    } sb_entry_t;

endpackage

// File: rtl/sb_forward_match.sv
// Youngest-match search over the buffered stores for load forwarding.
module sb_forward_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH      = SB_DEPTH,
    parameter int MATCH_BITS = SB_MATCH_BITS,
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]                 ent_valid,
    input  logic [DEPTH-1:0][MATCH_BITS-1:0] ent_addr,
    input  logic [DEPTH-1:0][15:0]           ent_data,
    input  logic [PW-1:0]                    head,
    input  logic [MATCH_BITS-1:0]            lookup_addr,
    output logic                             hit,
    output logic [15:0]                      hit_data
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (ent_valid[idx] && (ent_addr[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores drained to data memory, with load forwarding
// and a starvation guard that forces a drain after a run of load-priority cycles.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH        = SB_DEPTH,
    parameter int STARVE_LIMIT = SB_STARVE_LIMIT,
    parameter int MATCH_BITS   = SB_MATCH_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [15:0] mem_access_addr,
    output logic [15:0] mem_write_data,
    output logic        mem_write_en,
    output logic        mem_read,
    input  logic [15:0] mem_read_data,
    output logic        sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [15:0]           rsp_rdata_q, rsp_rdata_d;

    logic forced_drain, store_rdy, load_acc, store_acc, drain;
    logic fwd_hit;
    logic [15:0] fwd_data;

    logic [DEPTH-1:0]                 ent_valid;
    logic [DEPTH-1:0][MATCH_BITS-1:0] ent_addr;
    logic [DEPTH-1:0][15:0]           ent_data;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign ent_valid[g] = entries_q[g].valid;
        assign ent_addr[g]  = entries_q[g].addr[MATCH_BITS-1:0];
        assign ent_data[g]  = entries_q[g].data;
    end

    sb_forward_match #(
        .DEPTH      (DEPTH),
        .MATCH_BITS (MATCH_BITS)
    ) u_fwd (
        .ent_valid   (ent_valid),
        .ent_addr    (ent_addr),
        .ent_data    (ent_data),
        .head        (head_q),
        .lookup_addr (req_addr[MATCH_BITS-1:0]),
        .hit         (fwd_hit),
        .hit_data    (fwd_data)
    );

    // Loads win the memory port unless the starvation counter has run out.
    always_comb begin
        forced_drain = (starve_q == SW'(STARVE_LIMIT)) && (count_q != '0);
        store_rdy    = count_q < CW'(DEPTH);
        req_ready    = req_write ? store_rdy : !forced_drain;
        load_acc     = req_valid && !req_write && !forced_drain;
        store_acc    = req_valid && req_write && store_rdy;
        drain        = (count_q != '0) && !load_acc;
    end

    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (drain) begin
            mem_access_addr = entries_q[head_q].addr;
            mem_write_data  = entries_q[head_q].data;
            mem_write_en    = rst_n;
        end else if (load_acc && !fwd_hit) begin
            mem_access_addr = req_addr;
            mem_read        = 1'b1;
        end
    end

    always_comb begin
        entries_d   = entries_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + CW'(store_acc) - CW'(drain);
        starve_d    = starve_q;
        rsp_valid_d = load_acc;
        rsp_rdata_d = rsp_rdata_q;

        if (drain) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PW'(1);
        end
        // Push and pop never target the same slot: push needs count<DEPTH, pop needs count>0,
        // and the two indices only coincide at count==0 or count==DEPTH.
        if (store_acc) begin
            entries_d[tail_q].addr  = req_addr;
            entries_d[tail_q].data  = req_wdata;
            entries_d[tail_q].valid = 1'b1;
            tail_d                  = tail_q + PW'(1);
        end

        if (drain) begin
            starve_d = '0;
        end else if (load_acc && (count_q != '0)) begin
            starve_d = starve_q + SW'(1);
        end

        if (load_acc) begin
            rsp_rdata_d = fwd_hit ? fwd_data : mem_read_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            entries_q   <= entries_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sb_empty  = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, reset-abort sequence, and
// randomized traffic against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, mem_write_en, mem_read, sb_empty;
    logic [15:0] rsp_rdata, mem_access_addr, mem_write_data, mem_read_data;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data),
        .sb_empty        (sb_empty)
    );

    // Data memory: 8 words indexed by the low address bits.
    logic [15:0] mem [8];
    logic        init_req = 1'b1;
    assign mem_read_data = mem[mem_access_addr[2:0]];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h00FA + 16'(i);
        end else if (mem_write_en) begin
            mem[mem_access_addr[2:0]] <= mem_write_data;
        end
    end

    typedef struct {
        logic v, w; logic [15:0] a, d;
        logic rdy, wen, rd; logic [15:0] maddr, mwd;
        logic empty, rspv; logic [15:0] rspd;
    } vec_t;

    typedef struct { logic [15:0] a, d; } st_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    endtask

    vec_t tbl [17];
    st_t  sbq [$];
    logic [15:0] gmem [8];
    int   starve;
    logic exp_rspv;
    logic [15:0] exp_rspd;

    initial begin
        tbl[0]  = '{1,1,16'h0002,16'hA5A5, 1,0,0,16'h0000,16'h0000, 1,0,16'h0000};
        tbl[1]  = '{0,0,16'h0000,16'h0000, 1,1,0,16'h0002,16'hA5A5, 0,0,16'h0000};
        tbl[2]  = '{0,0,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000, 1,0,16'h0000};
        tbl[3]  = '{1,1,16'h0001,16'h1111, 1,0,0,16'h0000,16'h0000, 1,0,16'h0000};
        tbl[4]  = '{1,1,16'h0009,16'h2222, 1,1,0,16'h0001,16'h1111, 0,0,16'h0000};
        tbl[5]  = '{1,0,16'h0001,16'h0000, 1,0,0,16'h0000,16'h0000, 0,0,16'h0000};
        tbl[6]  = '{0,0,16'h0000,16'h0000, 1,1,0,16'h0009,16'h2222, 0,1,16'h2222};
        tbl[7]  = '{0,0,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000, 1,0,16'h0000};
        tbl[8]  = '{1,0,16'h0005,16'h0000, 1,0,1,16'h0005,16'h0000, 1,0,16'h0000};
        tbl[9]  = '{0,0,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000, 1,1,16'h00FF};
        tbl[10] = '{1,1,16'h0003,16'h3333, 1,0,0,16'h0000,16'h0000, 1,0,16'h0000};
        tbl[11] = '{1,0,16'h0006,16'h0000, 1,0,1,16'h0006,16'h0000, 0,0,16'h0000};
        tbl[12] = '{1,0,16'h0006,16'h0000, 1,0,1,16'h0006,16'h0000, 0,1,16'h0100};
        tbl[13] = '{1,0,16'h0006,16'h0000, 1,0,1,16'h0006,16'h0000, 0,1,16'h0100};
        tbl[14] = '{1,0,16'h0006,16'h0000, 1,0,1,16'h0006,16'h0000, 0,1,16'h0100};
        tbl[15] = '{1,0,16'h0006,16'h0000, 0,1,0,16'h0003,16'h3333, 0,1,16'h0100};
        tbl[16] = '{0,0,16'h0000,16'h0000, 1,0,0,16'h0000,16'h0000, 1,0,16'h0000};

        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        init_req = 1'b0;
        chk("reset sb_empty", 16'(sb_empty), 16'h1);
        chk("reset rsp_valid", 16'(rsp_valid), 16'h0);
        chk("reset rsp_rdata", rsp_rdata, 16'h0);
        chk("reset mem_write_en", 16'(mem_write_en), 16'h0);
        chk("reset load ready", 16'(req_ready), 16'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
            @(negedge clk);
            chk($sformatf("tbl%0d req_ready", i), 16'(req_ready), 16'(tbl[i].rdy));
            chk($sformatf("tbl%0d mem_write_en", i), 16'(mem_write_en), 16'(tbl[i].wen));
            chk($sformatf("tbl%0d mem_read", i), 16'(mem_read), 16'(tbl[i].rd));
            chk($sformatf("tbl%0d mem_access_addr", i), mem_access_addr, tbl[i].maddr);
            chk($sformatf("tbl%0d mem_write_data", i), mem_write_data, tbl[i].mwd);
            chk($sformatf("tbl%0d sb_empty", i), 16'(sb_empty), 16'(tbl[i].empty));
            chk($sformatf("tbl%0d rsp_valid", i), 16'(rsp_valid), 16'(tbl[i].rspv));
            if (tbl[i].rspv) chk($sformatf("tbl%0d rsp_rdata", i), rsp_rdata, tbl[i].rspd);
            @(posedge clk); #1;
        end

        // Reset asserted mid-cycle while a store is waiting to drain
        drive(1, 1, 16'h0004, 16'hDEAD);
        @(posedge clk); #1;
        drive(0, 0, 16'h0000, 16'h0000);
        #1;
        chk("pre-reset drain wen", 16'(mem_write_en), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset wen", 16'(mem_write_en), 16'h0);
        chk("async reset sb_empty", 16'(sb_empty), 16'h1);
        chk("async reset rsp_rdata", rsp_rdata, 16'h0);
        @(posedge clk); #1;
        chk("held reset wen", 16'(mem_write_en), 16'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 0, 16'h0004, 16'h0000);
        @(negedge clk);
        chk("post-reset load mem_read", 16'(mem_read), 16'h1);
        chk("post-reset load addr", mem_access_addr, 16'h0004);
        @(posedge clk); #1;
        drive(0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("post-reset rsp_valid", 16'(rsp_valid), 16'h1);
        chk("post-reset rsp_rdata", rsp_rdata, 16'h00FE);
        chk("discarded store never written", mem[4], 16'h00FE);

        // Randomized traffic against the reference model
        rst_n = 1'b0; init_req = 1'b1;
        @(posedge clk); @(negedge clk);
        init_req = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 8; i++) gmem[i] = 16'h00FA + 16'(i);
        sbq.delete();
        starve = 0; exp_rspv = 1'b0; exp_rspd = '0;
        @(posedge clk); #1;
        for (int c = 0; c < 800; c++) begin
            logic v, w, forced, e_rdy, lacc, sacc, drn, hit;
            logic [15:0] a, d, hd;
            int n;
            v = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) == 0);
            a = {($urandom_range(0, 1) != 0) ? 13'h0 : 13'($urandom), 3'($urandom)};
            d = 16'($urandom);
            drive(v, w, a, d);
            @(negedge clk);

            n      = sbq.size();
            forced = (starve == LIMIT) && (n > 0);
            e_rdy  = w ? (n < DEPTH) : !forced;
            lacc   = v && !w && !forced;
            sacc   = v && w && (n < DEPTH);
            drn    = (n > 0) && !lacc;
            hit = 1'b0; hd = '0;
            for (int k = n - 1; k >= 0; k--) begin
                if (sbq[k].a[2:0] == a[2:0]) begin hit = 1'b1; hd = sbq[k].d; break; end
            end

            chk("rnd req_ready", 16'(req_ready), 16'(e_rdy));
            chk("rnd mem_write_en", 16'(mem_write_en), 16'(drn));
            chk("rnd mem_read", 16'(mem_read), 16'(lacc && !hit));
            chk("rnd mem_access_addr", mem_access_addr,
                drn ? sbq[0].a : ((lacc && !hit) ? a : 16'h0));
            chk("rnd mem_write_data", mem_write_data, drn ? sbq[0].d : 16'h0);
            chk("rnd sb_empty", 16'(sb_empty), 16'(n == 0));
            chk("rnd rsp_valid", 16'(rsp_valid), 16'(exp_rspv));
            if (exp_rspv) chk("rnd rsp_rdata", rsp_rdata, exp_rspd);

            exp_rspv = lacc;
            if (lacc) exp_rspd = hit ? hd : gmem[a[2:0]];
            if (drn) starve = 0;
            else if (lacc && n > 0) starve++;
            if (drn) begin
                gmem[sbq[0].a[2:0]] = sbq[0].d;
                void'(sbq.pop_front());
            end
            if (sacc) sbq.push_back('{a, d});
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
